// File: rtl/zet_muldiv_seq.sv
// zet_muldiv_seq: multi-cycle 8086 MUL/IMUL/DIV/IDIV unit, byte and word forms.
// Multiply is radix-2 shift-add (LSB first); divide is restoring (MSB first).
// Results register on the edge entering DONE; `done` pulses for one cycle.
// Optional macro ZET_MUL_FAST_EN: single-cycle array multiply for MUL/IMUL.
module zet_muldiv_seq (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [1:0]  func,
    input  logic        word_op,
    input  logic [31:0] x,
    input  logic [15:0] y,
    output logic        busy,
    output logic        done,
    output logic [31:0] out,
    output logic        cfo,
    output logic        ofo,
    output logic        div_exc
);

    typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

    state_t      state;
    logic        is_div, is_sgn, wrd;
    logic        neg_q;      // result (product/quotient) must be negated
    logic        neg_r;      // remainder takes a negative dividend's sign
    logic [31:0] a_reg;      // shifting multiplicand, or dividend low half
    logic [15:0] b_reg;      // shifting multiplier, or divisor magnitude
    logic [31:0] acc;        // product accumulator
    logic [15:0] rem;        // partial remainder (always below the divisor)
    logic [15:0] quo;
    logic [3:0]  cnt;

    // Launch-time operand signs, magnitudes and the divide fault pre-check
    logic        xs, xd, ys, pre_fault;
    logic [15:0] mx, my, dhi, dlo;
    logic [31:0] md;

    // Fold signed operands to magnitudes and detect divide faults up front
    always_comb begin
        xs = word_op ? x[15] : x[7];
        xd = word_op ? x[31] : x[15];
        ys = word_op ? y[15] : y[7];
        mx = word_op ? x[15:0] : {8'd0, x[7:0]};
        if (func[0] && xs)
            mx = word_op ? (~x[15:0] + 16'd1) : {8'd0, ~x[7:0] + 8'd1};
        my = word_op ? y : {8'd0, y[7:0]};
        if (func[0] && ys)
            my = word_op ? (~y + 16'd1) : {8'd0, ~y[7:0] + 8'd1};
        md = word_op ? x : {16'd0, x[15:0]};
        if (func[0] && xd)
            md = word_op ? (~x + 32'd1) : {16'd0, ~x[15:0] + 16'd1};
        dhi = word_op ? md[31:16] : {8'd0, md[15:8]};
        dlo = word_op ? md[15:0]  : {8'd0, md[7:0]};
        // quotient cannot fit N bits when the upper half reaches the divisor
        pre_fault = (my == 16'd0) || (dhi >= my);
    end

    // Sign-correct a product and derive CF/OF; returns {flag, out}
    function automatic logic [32:0] mul_fix(input logic w, input logic sgn,
                                            input logic neg, input logic [31:0] p);
        logic [31:0] r;
        logic [15:0] r16;
        logic        f;
        r16 = neg ? (~p[15:0] + 16'd1) : p[15:0];
        if (w) begin
            r = neg ? (~p + 32'd1) : p;
            f = sgn ? (r[31:16] != {16{r[15]}}) : (r[31:16] != 16'd0);
        end else begin
            r = {16'd0, r16};
            f = sgn ? (r16[15:8] != {8{r16[7]}}) : (r16[15:8] != 8'd0);
        end
        return {f, r};
    endfunction

    logic [32:0] mul_res;
    logic [16:0] div_trial, div_sub;
    logic        div_ge;
    logic [15:0] q_s, r_s, q_lim;
    logic        div_ovf;
    logic [31:0] div_out;

    // Per-cycle restoring step and the FIX-stage result assembly
    always_comb begin
        mul_res   = mul_fix(wrd, is_sgn, neg_q, acc);
        div_trial = {rem, a_reg[{1'b0, cnt}]};
        div_sub   = div_trial - {1'b0, b_reg};
        div_ge    = div_trial >= {1'b0, b_reg};
        q_s       = neg_q ? (~quo + 16'd1) : quo;
        r_s       = neg_r ? (~rem + 16'd1) : rem;
        // a negative quotient may reach one step further than a positive one
        q_lim     = neg_q ? (wrd ? 16'h8000 : 16'h0080) : (wrd ? 16'h7FFF : 16'h007F);
        div_ovf   = is_sgn && (quo > q_lim);
        div_out   = wrd ? {r_s, q_s} : {16'd0, r_s[7:0], q_s[7:0]};
    end

`ifdef ZET_MUL_FAST_EN
    logic [31:0] fast_p;
    logic [32:0] fast_res;
    // Single-cycle magnitude product, sign-fixed like the iterative path
    always_comb begin
        fast_p   = {16'd0, mx} * {16'd0, my};
        fast_res = mul_fix(word_op, func[0], func[0] & (xs ^ ys), fast_p);
    end
`endif

    // Control FSM with registered busy/done/result outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            busy    <= 1'b0;
            done    <= 1'b0;
            div_exc <= 1'b0;
            out     <= 32'd0;
            cfo     <= 1'b0;
            ofo     <= 1'b0;
            is_div  <= 1'b0;
            is_sgn  <= 1'b0;
            wrd     <= 1'b0;
            neg_q   <= 1'b0;
            neg_r   <= 1'b0;
            a_reg   <= 32'd0;
            b_reg   <= 16'd0;
            acc     <= 32'd0;
            rem     <= 16'd0;
            quo     <= 16'd0;
            cnt     <= 4'd0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        is_div  <= func[1];
                        is_sgn  <= func[0];
                        wrd     <= word_op;
                        neg_q   <= func[0] & ((func[1] ? xd : xs) ^ ys);
                        neg_r   <= func[0] & xd;
                        a_reg   <= {16'd0, func[1] ? dlo : mx};
                        b_reg   <= my;
                        acc     <= 32'd0;
                        rem     <= dhi;
                        quo     <= 16'd0;
                        cnt     <= word_op ? 4'd15 : 4'd7;
                        div_exc <= 1'b0;
                        if (func[1] && pre_fault) begin
                            div_exc <= 1'b1;
                            done    <= 1'b1;
                            state   <= DONE;
                        end
`ifdef ZET_MUL_FAST_EN
                        else if (!func[1]) begin
                            out   <= fast_res[31:0];
                            cfo   <= fast_res[32];
                            ofo   <= fast_res[32];
                            done  <= 1'b1;
                            state <= DONE;
                        end
`endif
                        else begin
                            busy  <= 1'b1;
                            state <= CALC;
                        end
                    end else begin
                        state <= IDLE;
                    end
                end
                CALC: begin
                    if (is_div) begin
                        rem <= div_ge ? div_sub[15:0] : div_trial[15:0];
                        quo <= {quo[14:0], div_ge};
                    end else begin
                        acc   <= acc + (b_reg[0] ? a_reg : 32'd0);
                        a_reg <= a_reg << 1;
                        b_reg <= b_reg >> 1;
                    end
                    cnt <= cnt - 4'd1;
                    if (cnt == 4'd0) state <= FIX;
                end
                FIX: begin
                    busy  <= 1'b0;
                    done  <= 1'b1;
                    state <= DONE;
                    if (is_div) begin
                        if (div_ovf) begin
                            div_exc <= 1'b1;
                        end else begin
                            out <= div_out;
                            cfo <= 1'b0;
                            ofo <= 1'b0;
                        end
                    end else begin
                        out <= mul_res[31:0];
                        cfo <= mul_res[32];
                        ofo <= mul_res[32];
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_zet_muldiv_seq.sv
// Directed bench for zet_muldiv_seq: hand-computed results, flags and latency.
module tb_zet_muldiv_seq;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [1:0]  func = 2'b00;
    logic        word_op = 1'b0;
    logic [31:0] x = 32'd0;
    logic [15:0] y = 16'd0;
    logic        busy, done, cfo, ofo, div_exc;
    logic [31:0] out;

    int n_chk  = 0;
    int n_fail = 0;

`ifdef ZET_MUL_FAST_EN
    localparam int MUL_W = 1;
    localparam int MUL_B = 1;
`else
    localparam int MUL_W = 18;
    localparam int MUL_B = 10;
`endif

    zet_muldiv_seq dut (
        .clk(clk), .rst(rst), .start(start), .func(func), .word_op(word_op),
        .x(x), .y(y), .busy(busy), .done(done), .out(out),
        .cfo(cfo), .ofo(ofo), .div_exc(div_exc)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue one op in the current cycle and return in its done cycle
    task automatic run_op(input logic [1:0] f, input logic w, input logic [31:0] xx,
                          input logic [15:0] yy, output int cyc, output logic saw_busy);
        func = f; word_op = w; x = xx; y = yy; start = 1'b1;
        saw_busy = 1'b0;
        tick();
        start = 1'b0;
        cyc = 1;
        while (!done && cyc < 40) begin
            saw_busy |= busy;
            tick();
            cyc++;
        end
        if (!done) chk("done_timeout", 32'd0, 32'd1);
    endtask

    int   cyc;
    logic sb;
    logic early;

    initial begin
        tick(); tick();
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_out", out, 32'd0);
        chk("rst_flags", {29'd0, cfo, ofo, div_exc}, 32'd0);
        rst = 1'b0;
        tick();

        // MUL word
        run_op(2'b00, 1'b1, 32'h0000FFFF, 16'hFFFF, cyc, sb);
        chk("mulw_lat", cyc, MUL_W);
        chk("mulw_out", out, 32'hFFFE0001);
        chk("mulw_flags", {30'd0, cfo, ofo}, 32'd3);

        // IMUL byte, then back-to-back IMUL byte issued in the done cycle
        run_op(2'b01, 1'b0, 32'h000000FF, 16'h0002, cyc, sb);
        chk("imulb1_lat", cyc, MUL_B);
        chk("imulb1_out", out, 32'h0000FFFE);
        chk("imulb1_flags", {30'd0, cfo, ofo}, 32'd0);
        run_op(2'b01, 1'b0, 32'h00000040, 16'h0004, cyc, sb);
        chk("imulb2_lat", cyc, MUL_B);
        chk("imulb2_out", out, 32'h00000100);
        chk("imulb2_flags", {30'd0, cfo, ofo}, 32'd3);

        // IMUL word, negative product that fits the low half
        run_op(2'b01, 1'b1, 32'h0000FFFE, 16'h0003, cyc, sb);
        chk("imulw_out", out, 32'hFFFFFFFA);
        chk("imulw_flags", {30'd0, cfo, ofo}, 32'd0);

        // DIV word and byte
        run_op(2'b10, 1'b1, 32'h00010000, 16'h0003, cyc, sb);
        chk("divw_lat", cyc, 18);
        chk("divw_out", out, 32'h00015555);
        chk("divw_exc", {31'd0, div_exc}, 32'd0);
        chk("divw_flags", {30'd0, cfo, ofo}, 32'd0);
        run_op(2'b10, 1'b0, 32'h00000064, 16'h0007, cyc, sb);
        chk("divb_lat", cyc, 10);
        chk("divb_out", out, 32'h0000020E);

        // IDIV byte: -7 / 2 = -3 rem -1
        run_op(2'b11, 1'b0, 32'h0000FFF9, 16'h0002, cyc, sb);
        chk("idivb_out", out, 32'h0000FFFD);
        chk("idivb_exc", {31'd0, div_exc}, 32'd0);

        // IDIV word quotient +0x8000 overflows in FIX
        run_op(2'b11, 1'b1, 32'h00008000, 16'h0001, cyc, sb);
        chk("idivw_lat", cyc, 18);
        chk("idivw_exc", {31'd0, div_exc}, 32'd1);
        chk("idivw_out_held", out, 32'h0000FFFD);

        // Pre-check faults: divide by zero and upper half >= divisor
        run_op(2'b10, 1'b1, 32'h00001234, 16'h0000, cyc, sb);
        chk("dz_lat", cyc, 1);
        chk("dz_busy", {31'd0, sb}, 32'd0);
        chk("dz_exc", {31'd0, div_exc}, 32'd1);
        chk("dz_out_held", out, 32'h0000FFFD);
        run_op(2'b10, 1'b1, 32'h00050000, 16'h0005, cyc, sb);
        chk("ovf_lat", cyc, 1);
        chk("ovf_busy", {31'd0, sb}, 32'd0);
        chk("ovf_exc", {31'd0, div_exc}, 32'd1);
        tick();

        // Word DIV with stray starts in cycles 2..16
        func = 2'b10; word_op = 1'b1; x = 32'h00012345; y = 16'h0100; start = 1'b1;
        tick();
        early = 1'b0;
        for (int c = 1; c < 18; c++) begin
            start = (c >= 2 && c <= 16);
            if (start) begin
                func = 2'b00; word_op = 1'b0; x = $urandom; y = 16'h1234;
            end
            early |= done;
            tick();
        end
        start = 1'b0;
        chk("ign_early_done", {31'd0, early}, 32'd0);
        chk("ign_done18", {31'd0, done}, 32'd1);
        chk("ign_out", out, 32'h00450123);
        chk("ign_exc_clr", {31'd0, div_exc}, 32'd0);
        tick();

        // Reset pulse in cycle 7 of a word DIV
        func = 2'b10; word_op = 1'b1; x = 32'h00010000; y = 16'h0003; start = 1'b1;
        tick();
        start = 1'b0;
        for (int c = 1; c < 7; c++) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("mrst_busy", {31'd0, busy}, 32'd0);
        chk("mrst_done", {31'd0, done}, 32'd0);
        chk("mrst_out", out, 32'd0);
        early = 1'b0;
        for (int c = 0; c < 25; c++) begin
            early |= done;
            tick();
        end
        chk("mrst_no_done", {31'd0, early}, 32'd0);

        // Recovery after reset
        run_op(2'b10, 1'b0, 32'h00000064, 16'h0007, cyc, sb);
        chk("rec_lat", cyc, 10);
        chk("rec_out", out, 32'h0000020E);

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
